sram_arbiter: RTL

- Two-port arbiter and timing sequencer for the single async SRAM (8-bit data, 19-bit address).
- Shares the SRAM between two requesters, e.g. the memory tester engine and a host/debug port.
- Drives the SRAM pins directly with registered strobes and programmable wait states.
- Arbitration is round-robin; each access is atomic once granted.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_rr_pick.sv | 29 ++
 rtl/sram_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared constants for the two-port SRAM arbiter: state encodings,
// port indices and the wait-state counter width.
package sram_arb_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RD       = 3'd1;
  localparam logic [2:0] ST_WR_SETUP = 3'd2;
  localparam logic [2:0] ST_WR_PULSE = 3'd3;
  localparam logic [2:0] ST_WR_HOLD  = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/sram_rr_pick.sv
// Two-way round-robin picker: on a tie the port that was not granted last wins.
module sram_rr_pick
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       grant_en,
  output logic [1:0] gnt,
  output logic       last_nxt
);

  always_comb begin
    gnt      = 2'b00;
    last_nxt = last;
    if (grant_en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last == PORT1) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt[0])
      last_nxt = PORT0;
    else if (gnt[1])
      last_nxt = PORT1;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for an async SRAM; every strobe is
// registered and each granted access runs to completion before the next grant.
//
// state       | meaning
// ------------+---------------------------------------------------------
// IDLE        | no access; sample requests and grant one
// RD          | CE_N/OE_N low for RD_WAIT cycles, capture DQ on the last edge
// WR_SETUP    | CE_N low, DQ driven, WE_N still high
// WR_PULSE    | WE_N low for WR_WAIT cycles
// WR_HOLD     | WE_N high, DQ and CE_N held for data hold time
// DONE        | strobes high, DQ released, done pulse to granted port
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int SRAM_DATA_SIZE = 8,
  parameter int SRAM_ADDR_SIZE = 19,
  parameter int RD_WAIT        = 2,
  parameter int WR_WAIT        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      p0_req,
  input  logic                      p0_rnw,
  input  logic [SRAM_ADDR_SIZE-1:0] p0_addr,
  input  logic [SRAM_DATA_SIZE-1:0] p0_wdat,
  output logic                      p0_done,
  output logic [SRAM_DATA_SIZE-1:0] p0_rdat,
  input  logic                      p1_req,
  input  logic                      p1_rnw,
  input  logic [SRAM_ADDR_SIZE-1:0] p1_addr,
  input  logic [SRAM_DATA_SIZE-1:0] p1_wdat,
  output logic                      p1_done,
  output logic [SRAM_DATA_SIZE-1:0] p1_rdat,
  output logic                      busy,
  inout  wire  [SRAM_DATA_SIZE-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_SIZE-1:0] SRAM_ADDR,
  output logic                      SRAM_CE_N,
  output logic                      SRAM_OE_N,
  output logic                      SRAM_WE_N,
  output logic                      SRAM_UB_N,
  output logic                      SRAM_LB_N
);

  localparam logic [WAIT_W-1:0] RD_LOAD = WAIT_W'(RD_WAIT);
  localparam logic [WAIT_W-1:0] WR_LOAD = WAIT_W'(WR_WAIT);
  localparam logic [WAIT_W-1:0] CNT_TC  = WAIT_W'(1);

  logic [2:0]                state;
  logic [WAIT_W-1:0]         cnt;
  logic                      last_q;
  logic                      sel_q;
  logic [SRAM_DATA_SIZE-1:0] wdat_q;
  logic                      dq_oe;
  logic [1:0]                gnt;
  logic                      last_nxt;
  logic                      rnw_sel;

  sram_rr_pick u_pick (
    .req      ({p1_req, p0_req}),
    .last     (last_q),
    .grant_en (state == ST_IDLE),
    .gnt      (gnt),
    .last_nxt (last_nxt)
  );

  assign rnw_sel   = gnt[1] ? p1_rnw : p0_rnw;
  assign busy      = (state != ST_IDLE);
  assign SRAM_DQ   = dq_oe ? wdat_q : {SRAM_DATA_SIZE{1'bz}};
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last_q    <= PORT1;
      sel_q     <= PORT0;
      wdat_q    <= '0;
      dq_oe     <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      p0_done   <= 1'b0;
      p1_done   <= 1'b0;
      p0_rdat   <= '0;
      p1_rdat   <= '0;
    end else begin
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            last_q    <= last_nxt;
            sel_q     <= gnt[1];
            SRAM_ADDR <= gnt[1] ? p1_addr : p0_addr;
            wdat_q    <= gnt[1] ? p1_wdat : p0_wdat;
            SRAM_CE_N <= 1'b0;
            if (rnw_sel) begin
              SRAM_OE_N <= 1'b0;
              cnt       <= RD_LOAD;
              state     <= ST_RD;
            end else begin
              dq_oe <= 1'b1;
              state <= ST_WR_SETUP;
            end
          end
        end
        ST_RD: begin
          if (cnt == CNT_TC) begin
            if (sel_q == PORT1) begin
              p1_rdat <= SRAM_DQ;
              p1_done <= 1'b1;
            end else begin
              p0_rdat <= SRAM_DQ;
              p0_done <= 1'b1;
            end
            SRAM_OE_N <= 1'b1;
            SRAM_CE_N <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_TC;
          end
        end
        ST_WR_SETUP: begin
          SRAM_WE_N <= 1'b0;
          cnt       <= WR_LOAD;
          state     <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (cnt == CNT_TC) begin
            SRAM_WE_N <= 1'b1;
            state     <= ST_WR_HOLD;
          end else begin
            cnt <= cnt - CNT_TC;
          end
        end
        ST_WR_HOLD: begin
          SRAM_CE_N <= 1'b1;
          dq_oe     <= 1'b0;
          p0_done   <= (sel_q == PORT0);
          p1_done   <= (sel_q == PORT1);
          state     <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          SRAM_CE_N <= 1'b1;
          SRAM_OE_N <= 1'b1;
          SRAM_WE_N <= 1'b1;
          dq_oe     <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
